// File: rtl/zbt_mem_arbiter_pkg.sv
// Shared definitions for the ZBT SRAM arbiter:
// client ids, memory geometry and the read tag.
package zbt_mem_arbiter_pkg;

  localparam int NUM_CLIENTS    = 3;
  localparam int CLIENT_DISPLAY = 0;
  localparam int CLIENT_CAMERA  = 1;
  localparam int CLIENT_PROC    = 2;
  localparam int ZBT_ADDR_W     = 19;
  localparam int ZBT_DATA_W     = 36;

  typedef struct packed {
    logic       valid;
    logic [1:0] id;
  } tag_t;

  typedef enum logic {
    RR_CAMERA = 1'b0,
    RR_PROC   = 1'b1
  } rr_t;

  function automatic logic [2:0] id_onehot(
    input logic [1:0] id
  );
    return 3'(3'b001 << id);
  endfunction

endpackage

// File: rtl/zbt_mem_arbiter_read_tag_pipe.sv
// Shift register of read tags that tracks
// which client owns each read in the ZBT pipe.
module read_tag_pipe
  import zbt_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  tag_t             tag_in,
  output tag_t [DEPTH-1:0] stage
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

endmodule

// File: rtl/zbt_mem_arbiter.sv
// Three-client arbiter for one pipelined ZBT port:
// priority grant with starvation override, tagged reads.
module zbt_mem_arbiter
  import zbt_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ZBT_ADDR_W,
  parameter int DATA_W       = ZBT_DATA_W,
  parameter int READ_LATENCY = 2,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  output logic [2:0]            gnt,
  output logic [2:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int SW =
    (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  localparam bit OVR_EN = (STARVE_LIMIT > 0);

  logic [SW-1:0] starve_cam;
  logic [SW-1:0] starve_proc;
  rr_t           rr_ptr;
  logic          ovr_cam;
  logic          ovr_proc;
  logic [2:0]    gnt_raw;
  logic [1:0]    sel;
  logic          accept;
  tag_t          tag_in;
  logic [DATA_W-1:0] cap;

  tag_t [READ_LATENCY:0] tags;

  assign ovr_cam  = OVR_EN && req[CLIENT_CAMERA]
                    && (starve_cam == LIMIT);
  assign ovr_proc = OVR_EN && req[CLIENT_PROC]
                    && (starve_proc == LIMIT);

  // Starved clients beat the display; otherwise the
  // display beats the round-robin pair.
  always_comb begin
    gnt_raw = '0;
    if (ovr_cam) begin
      gnt_raw[CLIENT_CAMERA] = 1'b1;
    end else if (ovr_proc) begin
      gnt_raw[CLIENT_PROC] = 1'b1;
    end else if (req[CLIENT_DISPLAY]) begin
      gnt_raw[CLIENT_DISPLAY] = 1'b1;
    end else if (req[CLIENT_CAMERA] &&
                 (!req[CLIENT_PROC] ||
                  rr_ptr == RR_CAMERA)) begin
      gnt_raw[CLIENT_CAMERA] = 1'b1;
    end else if (req[CLIENT_PROC]) begin
      gnt_raw[CLIENT_PROC] = 1'b1;
    end
  end

  assign gnt    = reset ? gnt_raw : 3'b000;
  assign accept = |gnt;

  always_comb begin
    sel = 2'd0;
    unique case (1'b1)
      gnt[CLIENT_DISPLAY]: sel = 2'd0;
      gnt[CLIENT_CAMERA]:  sel = 2'd1;
      gnt[CLIENT_PROC]:    sel = 2'd2;
      default:             sel = 2'd0;
    endcase
  end

  assign tag_in.valid = accept & ~we[sel];
  assign tag_in.id    = sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cam  <= '0;
      starve_proc <= '0;
      rr_ptr      <= RR_CAMERA;
    end else begin
      if (req[CLIENT_CAMERA] && !gnt[CLIENT_CAMERA]) begin
        if (starve_cam != LIMIT)
          starve_cam <= starve_cam + 1'b1;
      end else begin
        starve_cam <= '0;
      end
      if (req[CLIENT_PROC] && !gnt[CLIENT_PROC]) begin
        if (starve_proc != LIMIT)
          starve_proc <= starve_proc + 1'b1;
      end else begin
        starve_proc <= '0;
      end
      if (gnt[CLIENT_CAMERA])
        rr_ptr <= RR_PROC;
      else if (gnt[CLIENT_PROC])
        rr_ptr <= RR_CAMERA;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_we <= accept & we[sel];
      if (accept) begin
        mem_addr  <= addr[sel*ADDR_W +: ADDR_W];
        mem_wdata <= wdata[sel*DATA_W +: DATA_W];
      end
    end
  end

  read_tag_pipe #(
    .DEPTH (READ_LATENCY + 1)
  ) u_tag_pipe (
    .clk    (clk),
    .reset  (reset),
    .tag_in (tag_in),
    .stage  (tags)
  );

  // Capture on the edge the ZBT data is due, then
  // present it one edge later with its owner's strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap    <= '0;
      rdata  <= '0;
      rvalid <= '0;
    end else begin
      if (tags[READ_LATENCY-1].valid)
        cap <= mem_rdata;
      rvalid <= tags[READ_LATENCY].valid
                ? id_onehot(tags[READ_LATENCY].id)
                : 3'b000;
      if (tags[READ_LATENCY].valid)
        rdata <= cap;
    end
  end

endmodule
